// File: rtl/pe_conv1d_mc.sv
// Multi-channel 1D convolution PE: per-channel K-tap delay lines, run-time weights,
// cross-channel accumulation with bias and optional ReLU, 2-deep FWFT output buffer.
module pe_conv1d_mc #(
  parameter  int unsigned N     = 16,
  parameter  int unsigned K     = 7,
  parameter  int unsigned CIN   = 4,
  parameter  int unsigned ACC_W = 2*N + $clog2(K*CIN+1) + 1,
  localparam int unsigned AW    = $clog2(K*CIN+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    relu_en,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [N-1:0]     in_data,
  input  logic                    w_we,
  input  logic [AW-1:0]           w_addr,
  input  logic signed [N-1:0]     w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);
  localparam int unsigned PW   = 2*N;
  localparam int unsigned NW   = K*CIN;
  localparam int unsigned CH_W = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int unsigned KW   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned TS_W = $clog2(K+1);

  logic signed [N-1:0]     x_q [CIN][K];
  logic signed [N-1:0]     x_d [CIN][K];
  logic signed [N-1:0]     w_q [CIN][K];
  logic signed [N-1:0]     w_d [CIN][K];
  logic signed [N-1:0]     bias_q, bias_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [TS_W-1:0]         ts_q, ts_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_last_q, s1_last_d;
  logic                    s1_emit_q, s1_emit_d;
  logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] done_q, done_d;
  logic                    done_valid_q, done_valid_d;
  logic signed [ACC_W-1:0] head_q, head_d;
  logic signed [ACC_W-1:0] tail_q, tail_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    in_ready_q, in_ready_d;

  logic                    accept, last_beat, push, pop;
  logic signed [N-1:0]     win  [K];
  logic signed [PW-1:0]    prod [K];
  logic signed [ACC_W-1:0] tree_sum, res;

  assign in_ready  = in_ready_q;
  assign out_valid = valid_q;
  assign out_data  = head_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q          <= '{default: '0};
      w_q          <= '{default: '0};
      bias_q       <= '0;
      ch_q         <= '0;
      ts_q         <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_emit_q    <= 1'b0;
      s1_sum_q     <= '0;
      acc_q        <= '0;
      done_q       <= '0;
      done_valid_q <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      x_q          <= x_d;
      w_q          <= w_d;
      bias_q       <= bias_d;
      ch_q         <= ch_d;
      ts_q         <= ts_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s1_emit_q    <= s1_emit_d;
      s1_sum_q     <= s1_sum_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      done_valid_q <= done_valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  always_comb begin
    x_d          = x_q;
    w_d          = w_q;
    bias_d       = bias_q;
    ch_d         = ch_q;
    ts_d         = ts_q;
    s1_valid_d   = 1'b0;
    s1_last_d    = 1'b0;
    s1_emit_d    = 1'b0;
    s1_sum_d     = '0;
    acc_d        = acc_q;
    done_d       = done_q;
    done_valid_d = 1'b0;
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    tree_sum     = '0;

    accept    = in_valid && in_ready_q && !clear;
    last_beat = (ch_q == CH_W'(CIN-1));

    // Window of the current channel after shifting in the new sample
    win[0] = in_data;
    for (int unsigned k = 1; k < K; k++) win[k] = x_q[ch_q][KW'(k-1)];
    for (int unsigned k = 0; k < K; k++) begin
      prod[k]  = PW'(w_q[ch_q][KW'(k)]) * PW'(win[k]);
      tree_sum = tree_sum + ACC_W'(prod[k]);
    end

    if (w_we) begin
      for (int unsigned c = 0; c < CIN; c++)
        for (int unsigned k = 0; k < K; k++)
          if (w_addr == AW'(c*K + k)) w_d[CH_W'(c)][KW'(k)] = w_data;
      if (w_addr == AW'(NW)) bias_d = w_data;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_last_d  = last_beat;
      s1_emit_d  = last_beat && (ts_q >= TS_W'(K-1));
      s1_sum_d   = tree_sum;
      for (int unsigned k = 0; k < K; k++) x_d[ch_q][KW'(k)] = win[k];
      ch_d = last_beat ? '0 : ch_q + CH_W'(1);
      if (last_beat && ts_q != TS_W'(K)) ts_d = ts_q + TS_W'(1);
    end

    if (s1_valid_q) begin
      if (s1_last_q) begin
        done_d       = acc_q + s1_sum_q + ACC_W'(bias_q);
        done_valid_d = s1_emit_q;
        acc_d        = '0;
      end else begin
        acc_d = acc_q + s1_sum_q;
      end
    end

    // Output buffer: push never sees a full FIFO because in_ready reserves space
    res  = (relu_en && done_q[ACC_W-1]) ? '0 : done_q;
    push = done_valid_q;
    pop  = valid_q && out_ready;
    unique case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = res;
        else               tail_d = res;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = res;
        end else begin
          head_d = tail_q;
          tail_d = res;
        end
      end
      default: ;
    endcase

    if (clear) begin
      x_d          = '{default: '0};
      ch_d         = '0;
      ts_d         = '0;
      s1_valid_d   = 1'b0;
      s1_last_d    = 1'b0;
      s1_emit_d    = 1'b0;
      s1_sum_d     = '0;
      acc_d        = '0;
      done_d       = '0;
      done_valid_d = 1'b0;
      head_d       = '0;
      tail_d       = '0;
      cnt_d        = '0;
    end

    valid_d    = (cnt_d != 2'd0);
    in_ready_d = (ch_d != CH_W'(CIN-1)) ||
                 ((3'(cnt_d) + 3'(s1_emit_d) + 3'(done_valid_d)) < 3'd2);
  end

endmodule

// File: tb/tb_pe_conv1d_mc.sv
// Directed bench for pe_conv1d_mc: table of constant-stream vectors plus
// hand-written latency, single-tap, clear, backpressure and reset sequences.
module tb_pe_conv1d_mc;
  localparam int unsigned N     = 16;
  localparam int unsigned K     = 7;
  localparam int unsigned CIN   = 4;
  localparam int unsigned ACC_W = 38;
  localparam int unsigned AW    = 5;

  logic                    clk = 1'b0;
  logic                    rst, clear, relu_en, in_valid, in_ready;
  logic signed [N-1:0]     in_data, w_data;
  logic                    w_we, out_valid, out_ready;
  logic [AW-1:0]           w_addr;
  logic signed [ACC_W-1:0] out_data;

  always #5 clk = ~clk;

  pe_conv1d_mc dut (
    .clk(clk), .rst(rst), .clear(clear), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  int checks   = 0;
  int failures = 0;
  logic signed [ACC_W-1:0] got[$];
  logic signed [ACC_W-1:0] expq[$];

  always @(posedge clk) if (rst && out_valid && out_ready) got.push_back(out_data);

  typedef struct {
    logic signed [N-1:0]     x;
    logic signed [N-1:0]     w;
    logic signed [N-1:0]     b;
    logic                    relu;
    logic signed [ACC_W-1:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int addr, input logic signed [N-1:0] d);
    w_we = 1'b1; w_addr = AW'(addr); w_data = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic load_all(input logic signed [N-1:0] w, input logic signed [N-1:0] b);
    for (int i = 0; i < K*CIN; i++) wr(i, w);
    wr(K*CIN, b);
  endtask

  task automatic send(input logic signed [N-1:0] x);
    int n = 0;
    in_valid = 1'b1; in_data = x;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
    end else begin
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic stream_const(input logic signed [N-1:0] x, input int steps);
    for (int i = 0; i < steps*CIN; i++) send(x);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_stream(input string name);
    check({name, "_count"}, longint'(got.size()), longint'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < got.size()) begin
        check($sformatf("%s_r%0d", name, i), longint'(got[i]), longint'(expq[i]));
      end else begin
        checks++; failures++;
        $display("FAIL %s_r%0d: result missing, expected %0d", name, i, expq[i]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{x: 16'sd1,     w: 16'sd1,     b: 16'sd0,     relu: 1'b0, exp: 38'sd28};
    vecs[1] = '{x: 16'sh8000,  w: 16'sh8000,  b: 16'sd32767, relu: 1'b0, exp: 38'sd30064803839};
    vecs[2] = '{x: 16'sd3,     w: 16'shFFFE,  b: 16'sd5,     relu: 1'b0, exp: -38'sd163};
    vecs[3] = '{x: 16'sd3,     w: 16'shFFFE,  b: 16'sd5,     relu: 1'b1, exp: 38'sd0};
    vecs[4] = '{x: 16'sh8000,  w: 16'sd32767, b: 16'sh8000,  relu: 1'b0, exp: -38'sd30063886336};
    vecs[5] = '{x: 16'sd100,   w: 16'sd7,     b: 16'shFC18,  relu: 1'b1, exp: 38'sd18600};

    rst = 1'b0; clear = 1'b0; relu_en = 1'b0; in_valid = 1'b0; in_data = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    tick();
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("reset_in_ready", longint'(in_ready), 1);

    // Latency of the first valid result
    load_all(16'sd1, 16'sd0);
    got.delete();
    for (int i = 0; i < 27; i++) send(16'sd1);
    send(16'sd1);
    check("lat_valid_c1", longint'(out_valid), 0);
    tick();
    check("lat_valid_c2", longint'(out_valid), 0);
    tick();
    check("lat_valid_c3", longint'(out_valid), 1);
    check("lat_data_c3", longint'(out_data), 28);
    stream_const(16'sd1, 1);
    repeat (10) tick();
    expq = '{38'sd28, 38'sd28};
    check_stream("lat");

    for (int i = 0; i < 6; i++) begin
      pulse_clear();
      relu_en = vecs[i].relu;
      load_all(vecs[i].w, vecs[i].b);
      got.delete();
      stream_const(vecs[i].x, 8);
      repeat (10) tick();
      expq = '{vecs[i].exp, vecs[i].exp};
      check_stream($sformatf("vec%0d", i));
    end

    // Single tap w[2][6] with an impulse on ch2, with and without ReLU
    for (int r = 0; r < 2; r++) begin
      pulse_clear();
      relu_en = r[0];
      load_all(16'sd0, 16'sd0);
      wr(2*K + 6, 16'shFFFB);
      got.delete();
      for (int t = 0; t < 8; t++)
        for (int c = 0; c < CIN; c++) send((t == 0 && c == 2) ? 16'sd100 : 16'sd0);
      repeat (10) tick();
      if (r == 0) expq = '{-38'sd500, 38'sd0};
      else        expq = '{38'sd0, 38'sd0};
      check_stream($sformatf("tap_relu%0d", r));
    end

    // clear mid-step after a saturated warm-up; weights loaded before clear must survive
    relu_en = 1'b0;
    load_all(16'sd1, 16'sd0);
    send(16'sd9);
    send(16'sd9);
    pulse_clear();
    got.delete();
    stream_const(16'sd1, 8);
    repeat (10) tick();
    expq = '{38'sd28, 38'sd28};
    check_stream("clear");

    // Backpressure: only tap 0 of each channel, step t result = 40t+6
    pulse_clear();
    load_all(16'sd0, 16'sd0);
    for (int c = 0; c < CIN; c++) wr(c*K, 16'sd1);
    out_ready = 1'b0;
    got.delete();
    for (int b = 0; b < 35; b++) send(N'((b / 4) * 10 + (b % 4)));
    repeat (4) tick();
    check("bp_in_ready_low", longint'(in_ready), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    check("bp_head", longint'(out_data), 246);
    in_valid = 1'b1; in_data = 16'sd83;
    repeat (3) tick();
    check("bp_still_blocked", longint'(in_ready), 0);
    out_ready = 1'b1;
    send(16'sd83);
    for (int b = 36; b < 48; b++) send(N'((b / 4) * 10 + (b % 4)));
    repeat (10) tick();
    expq = '{38'sd246, 38'sd286, 38'sd326, 38'sd366, 38'sd406, 38'sd446};
    check_stream("bp");

    // Asynchronous reset with results pending
    pulse_clear();
    load_all(16'sd1, 16'sd0);
    out_ready = 1'b0;
    stream_const(16'sd1, 8);
    repeat (4) tick();
    check("prerst_out_valid", longint'(out_valid), 1);
    #3 rst = 1'b0;
    #1;
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_out_data", longint'(out_data), 0);
    check("midrst_in_ready", longint'(in_ready), 1);
    #2 rst = 1'b1;
    tick();
    out_ready = 1'b1;
    got.delete();
    stream_const(16'sd1, 8);
    repeat (10) tick();
    expq = '{38'sd0, 38'sd0};
    check_stream("rst_weights");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_conv1d_mc.md
Name: pe_conv1d_mc

Overview:
Parametrised multi-channel 1D-convolution processing element for the ECG CNN datapath. It is the successor to the fixed 7-tap PE. It accepts a channel-interleaved sample stream, keeps a K-deep delay line per input channel and multiplies each channel's window by run-time-loadable weights. It accumulates across CIN channels, adds a bias, optionally applies ReLU, and emits one full-precision result per time step through a ready/valid output buffer.

Parameters:
N, 16, signed sample and weight width
K, 7, kernel taps per channel
CIN, 4, input channels accumulated per output
ACC_W, 2*N+$clog2(K*CIN+1)+1, signed result width (38 at defaults)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clear  in  1  synchronous flush of stream state
relu_en  in  1  1 = clamp negative results to 0
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&in_ready
in_data  in  N  signed sample; beats ordered ch0..ch(CIN-1) per time step
w_we  in  1  weight/bias write strobe
w_addr  in  $clog2(K*CIN+1)  c*K+k = weight (k=0 newest tap); K*CIN = bias
w_data  in  N  signed weight/bias, bias sign-extended to ACC_W
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  ACC_W  signed result

Behaviour:
- Reset (rst=0, async): delay lines, weights, bias, channel counter, warm-up counter, accumulator, pipeline and output FIFO are cleared. out_valid=0, out_data=0, in_ready=1.
- clear=1 (sync): same as reset, except weights and bias are retained and the bit is ignored for w_we. clear takes priority over a same-cycle beat.
- Channel counter ch: increments per accepted beat and wraps CIN-1 -> 0. A wrap ends a time step.
- Accepted beat on channel c: shift in_data into delay line c (taps k=0..K-1).
- Stage 1 (registered): K products w[c][k]*x[c][k] and their adder-tree sum, all at full precision.
- Stage 2: accumulator adds the stage-1 sum. On the last channel it loads acc+sum+bias into a completion register and restarts acc at 0.
- Latency: result of a time step is pushed to the output FIFO 2 cycles after its last beat is accepted. out_valid rises in the next cycle if the FIFO was empty.
- Warm-up: the time-step counter saturates at K. Results are produced only for time steps with index >= K-1 (valid convolution, no padding). Earlier completions are discarded.
- ReLU: applied when the result enters the FIFO, using the relu_en value sampled at that time.
- Output FIFO: depth 2, first-word fall-through.
- in_ready = (fifo_count + completions_in_flight < 2) OR the current beat is not a last-channel beat. No result is ever dropped or overwritten.
- Simultaneous FIFO push and pop: count is unchanged and order is preserved.
- Weight writes: take effect the cycle after w_we. A beat accepted in the same cycle uses the old weights. Writes are allowed while streaming.
- Arithmetic: two's complement throughout. No saturation (ACC_W is sized to be exact). Out-of-range w_addr writes are ignored.
- Reset mid-operation: any partial time step and in-flight results are lost, and the output clears immediately.

Test Plan:
1. Reset: assert rst=0 mid-stream -> out_valid=0, out_data=0, in_ready=1 immediately; all weight readbacks via test stream are 0.
2. All weights=1, bias=0, stream x=1 on every channel -> first result on the 7th time step (beat 28) = 28, out_valid high 3 cycles after beat 28. Every subsequent step = 28.
3. Single tap: w[2][6]=-5 only, impulse 100 on ch2 at t=0, zeros elsewhere -> first result = -500 and all later results = 0. Repeat with relu_en=1 -> first result = 0.
4. Extremes: all x=-32768, all w=-32768, bias=32767 -> result = 30064803839, no overflow.
5. Backpressure: hold out_ready=0 while streaming. The FIFO fills to 2 and in_ready drops on the next last-channel beat. Release out_ready -> results emerge in order with none lost or duplicated.
6. clear after 2 beats of a time step, then a fresh stream -> outputs match a clean run, weights retained, warm-up restarts (7 steps before the first result).
